// File: rtl/dt_pkg.sv
// dt_pkg: shared widths, requester-id width helper and arbiter state encoding
package dt_pkg;
    localparam int DT_ADDR_W = 14;
    localparam int DT_DATA_W = 8;
    localparam int DT_IMG_W = 128;
    typedef enum logic {ARB_IDLE, ARB_OWNED} arb_state_t;
    function automatic int req_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/dt_rr_pick.sv
// dt_rr_pick: first set request at or after the pointer, wrapping, as one-hot plus index
module dt_rr_pick #(
    parameter int N_REQ = 3,
    parameter int IW = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IW-1:0]    idx
);
    always_comb begin
        int j;
        j = 0;
        gnt = '0;
        idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            j = (j >= N_REQ) ? j - N_REQ : j;
            if (|(req & (N_REQ'(1) << j))) begin
                gnt = N_REQ'(1) << j;
                idx = IW'(j);
            end
        end
    end
endmodule

// File: rtl/dt_res_port_arbiter.sv
// dt_res_port_arbiter: round-robin arbiter with lock for the single-port result RAM
module dt_res_port_arbiter
    import dt_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int RD_LAT = 1,
    parameter int MAX_LOCK = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           lock,
    input  logic [N_REQ-1:0]           wr,
    input  logic [N_REQ*DT_ADDR_W-1:0] addr,
    input  logic [N_REQ*DT_DATA_W-1:0] wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           rvalid,
    output logic [DT_DATA_W-1:0]       rdata,
    output logic                       res_rd,
    output logic                       res_wr,
    output logic [DT_ADDR_W-1:0]       res_addr,
    output logic [DT_DATA_W-1:0]       res_do,
    input  logic [DT_DATA_W-1:0]       res_di,
    output logic                       lock_abort
);
    localparam int IW = req_id_w(N_REQ);
    localparam int CW = $clog2(MAX_LOCK + 1);
    arb_state_t state;
    logic [IW-1:0] owner, ptr, pick_idx, win;
    logic [CW-1:0] cnt;
    logic [N_REQ-1:0] pick_gnt, own_oh, acc;
    logic win_wr, win_lock, own_lock;
    logic [RD_LAT:0] tag_vld;
    logic [IW-1:0] tag_id [RD_LAT+1];
    dt_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req(req),
        .ptr(ptr),
        .gnt(pick_gnt),
        .idx(pick_idx)
    );
    // an owner keeps the grant even in cycles where it issues nothing
    assign own_oh = N_REQ'(1) << owner;
    assign gnt = reset ? '0 : (state == ARB_OWNED) ? own_oh : pick_gnt;
    assign acc = gnt & req;
    assign win = (state == ARB_OWNED) ? owner : pick_idx;
    assign win_wr = |(wr & acc);
    assign win_lock = |(lock & acc);
    assign own_lock = |(lock & own_oh);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            owner <= '0;
            ptr <= '0;
            cnt <= '0;
            res_rd <= 1'b0;
            res_wr <= 1'b0;
            res_addr <= '0;
            res_do <= '0;
            lock_abort <= 1'b0;
            rvalid <= '0;
            rdata <= '0;
            tag_vld <= '0;
            for (int k = 0; k <= RD_LAT; k++) tag_id[k] <= '0;
        end else begin
            res_rd <= |acc & ~win_wr;
            res_wr <= |acc & win_wr;
            if (|acc) begin
                res_addr <= addr[DT_ADDR_W*int'(win) +: DT_ADDR_W];
                res_do <= wdata[DT_DATA_W*int'(win) +: DT_DATA_W];
            end
            tag_vld <= {tag_vld[RD_LAT-1:0], |acc & ~win_wr};
            tag_id[0] <= win;
            for (int k = 1; k <= RD_LAT; k++) tag_id[k] <= tag_id[k-1];
            rvalid <= tag_vld[RD_LAT] ? N_REQ'(1) << tag_id[RD_LAT] : '0;
            if (tag_vld[RD_LAT]) rdata <= res_di;
            lock_abort <= 1'b0;
            if (state == ARB_IDLE) begin
                if (|acc) begin
                    ptr <= (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
                    if (win_lock) begin
                        state <= ARB_OWNED;
                        owner <= pick_idx;
                        cnt <= CW'(1);
                    end
                end
            end else if (!own_lock) begin
                state <= ARB_IDLE;
            end else if (cnt == CW'(MAX_LOCK - 1)) begin
                state <= ARB_IDLE;
                lock_abort <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule
